rule_order_seq: RTL and testbench
=================================

RULE_ORDER_SEQ -- requirements
Module: rule_order_seq

Interface
REQ-001 Parameter RULES, default 61: rules per round; slot and table depth.
REQ-002 Parameter PW, default 6: width of priority and rule index; 2^PW SHALL be >= RULES.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream priority value present.
REQ-006 in_prio  input  PW  priority of the next rule from the upstream priority generator.
REQ-007 in_ready  output  1  block accepts in_prio this cycle.
REQ-008 out_valid  output  1  out_rule holds a scheduled rule index.
REQ-009 out_rule  output  PW  rule index to update next.
REQ-010 out_ready  input  1  datapath consumes out_rule.
REQ-011 round_done  output  1  one-cycle pulse after the last rule of a round is consumed.
REQ-012 round_count  output  16  completed rounds, modulo 2^16.

Function
REQ-013 Two banks SHALL exist, each a RULES-entry slot table plus an occupancy bitmap: a fill bank (written from input) and an issue bank (read to output).
REQ-014 Input transfer SHALL occur when in_valid and in_ready are both 1; the k-th transfer of a round (k = 0..RULES-1) carries the priority of rule index k.
REQ-015 Start slot SHALL be in_prio if in_prio < RULES, otherwise slot 0.
REQ-016 Fill FSM states: FILL, PROBE, FULL; in_ready SHALL be 1 only in FILL.
REQ-017 FILL: on transfer, if the start slot is free, rule k SHALL be written there at that edge and the FSM SHALL stay in FILL (zero-stall accept).
REQ-018 FILL: on transfer, if the start slot is occupied, the FSM SHALL enter PROBE with cursor = (start+1) mod RULES and rule k held internally.
REQ-019 PROBE: each cycle, check one slot at the cursor; if free, write rule k and return to FILL; otherwise cursor = (cursor+1) mod RULES, wrapping RULES-1 -> 0.
REQ-020 When the RULES-th rule is written, whether from FILL or PROBE, the FSM SHALL enter FULL.
REQ-021 FULL -> FILL swap SHALL occur on the edge where the FSM is in FULL and out_valid is 0.
  - The filled bank becomes the issue bank, issue pointer = 0, out_valid = 1.
  - The new fill bank's bitmap is cleared and the input count is reset to 0.
REQ-022 While out_valid is 1, out_rule SHALL equal issue-bank slot[issue pointer] and SHALL remain stable until a handshake.
REQ-023 Handshake (out_valid & out_ready) at pointer < RULES-1 SHALL increment the pointer.
REQ-024 Handshake at pointer RULES-1 SHALL, on the same edge:
  - clear out_valid;
  - set round_done = 1 for exactly one cycle;
  - increment round_count, wrapping 65535 -> 0.
REQ-025 A swap SHALL NOT occur on the same edge as the final handshake, so there is exactly one bubble cycle between rounds.
REQ-026 Fill and issue SHALL proceed concurrently; filling the next round SHALL NOT alter the issue bank.
REQ-027 Every round output SHALL be a permutation of 0..RULES-1; a probe SHALL take at most RULES-1 cycles.

Reset
REQ-028 When rst = 0 at an edge, the block SHALL reset as follows:
  - outputs: out_valid = 0, round_done = 0, round_count = 0, out_rule = 0;
  - fill FSM = FILL, input count = 0, both bitmaps cleared, issue pointer = 0;
  - a partially filled or partially issued round is discarded.
REQ-029 Reset SHALL take precedence over all handshakes in the same cycle; in_ready SHALL be 1 on the first cycle after reset release.

Verification
REQ-030 Reset: hold rst = 0 for 2 cycles, then release -> out_valid = 0, round_count = 0, round_done = 0, in_ready = 1.
REQ-031 Distinct priorities:
  - Stimulus: in_prio = 60-k for k = 0..60, in_valid held 1, out_ready = 1.
  - Response: in_ready never drops; after the swap out_rule = 60, 59, ..., 0 on consecutive cycles; one round_done pulse; round_count = 1.
REQ-032 All priorities 0:
  - Stimulus: 61 transfers of in_prio = 0.
  - Response: rule k lands in slot k; in_ready is low for exactly k cycles after transfer k; output order is 0, 1, ..., 60.
REQ-033 Wrap and out-of-range priority:
  - Collision: rule 0 prio 60, rule 1 prio 60 -> rule 1 lands in slot 0 after 1 probe cycle.
  - Out-of-range: rule 2 prio 63 -> starts probing at slot 0, lands in slot 1 after 1 probe cycle.
REQ-034 Backpressure:
  - Stimulus: out_ready = 0 after the first round is issued; feed a second full round.
  - Response: out_rule is stable; fill FSM reaches FULL with in_ready = 0; once out_ready = 1, the 61 rules drain, then one bubble cycle, then the second round appears.
REQ-035 Reset mid-issue: assert rst = 0 while the issue pointer = 30 -> next cycle out_valid = 0 and round_count = 0; a subsequent full round issues correctly from slot 0.

Source files
------------

// File: rtl/rule_order_seq.sv
// Double-buffered rule scheduler: rules are placed into a slot table by priority
// (linear probing on collision) in one bank while the other bank is issued in slot order.
module rule_order_seq #(
    parameter int RULES = 61,
    parameter int PW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [PW-1:0] in_prio,
    output logic          in_ready,
    output logic          out_valid,
    output logic [PW-1:0] out_rule,
    input  logic          out_ready,
    output logic          round_done,
    output logic [15:0]   round_count
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PROBE = 2'd1,
        FULL  = 2'd2
    } fill_state_t;

    localparam logic [PW:0]   RULES_W = (PW+1)'(RULES);
    localparam logic [PW-1:0] LAST    = PW'(RULES - 1);

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        return (v == LAST) ? '0 : v + PW'(1);
    endfunction

    fill_state_t   state_r, state_s;
    logic [PW-1:0] cnt_r, cnt_s;
    logic [PW-1:0] cursor_r, cursor_s;
    logic [PW-1:0] hold_r, hold_s;
    logic          fill_sel_r;
    logic          issue_sel_s;
    logic [PW-1:0] slot_r [2][RULES];
    logic [RULES-1:0] occ_r [2];
    logic [RULES-1:0] fill_occ_s;
    logic [PW-1:0] start_s;
    logic          wr_en_s;
    logic [PW-1:0] wr_addr_s;
    logic [PW-1:0] wr_data_s;
    logic          swap_s;
    logic [PW-1:0] ptr_r;
    logic          out_valid_r;
    logic [PW-1:0] out_rule_r;
    logic          round_done_r;
    logic [15:0]   round_count_r;

    assign in_ready    = (state_r == FILL);
    assign out_valid   = out_valid_r;
    assign out_rule    = out_rule_r;
    assign round_done  = round_done_r;
    assign round_count = round_count_r;
    assign issue_sel_s = ~fill_sel_r;
    assign fill_occ_s  = occ_r[fill_sel_r];

    // Out-of-range priorities fold onto slot 0
    always_comb begin
        if ({1'b0, in_prio} < RULES_W) begin
            start_s = in_prio;
        end else begin
            start_s = '0;
        end
    end

    // Fill FSM next state, slot write request and bank swap request
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        cursor_s  = cursor_r;
        hold_s    = hold_r;
        wr_en_s   = 1'b0;
        wr_addr_s = start_s;
        wr_data_s = cnt_r;
        swap_s    = 1'b0;
        case (state_r)
            FILL: begin
                if (in_valid) begin
                    cnt_s = cnt_r + PW'(1);
                    if (!fill_occ_s[start_s]) begin
                        wr_en_s = 1'b1;
                        if (cnt_r == LAST) begin
                            state_s = FULL;
                        end else begin
                            state_s = FILL;
                        end
                    end else begin
                        state_s  = PROBE;
                        cursor_s = wrap_inc(start_s);
                        hold_s   = cnt_r;
                    end
                end else begin
                    state_s = FILL;
                end
            end
            PROBE: begin
                if (!fill_occ_s[cursor_r]) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = cursor_r;
                    wr_data_s = hold_r;
                    state_s   = (hold_r == LAST) ? FULL : FILL;
                end else begin
                    cursor_s = wrap_inc(cursor_r);
                end
            end
            FULL: begin
                // Swap only once the previous round has fully drained (bubble cycle)
                if (!out_valid_r) begin
                    swap_s  = 1'b1;
                    cnt_s   = '0;
                    state_s = FILL;
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = FILL;
            end
        endcase
    end

    // Fill FSM state register and bank selector
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= FILL;
            cnt_r      <= '0;
            cursor_r   <= '0;
            hold_r     <= '0;
            fill_sel_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            cursor_r   <= cursor_s;
            hold_r     <= hold_s;
            fill_sel_r <= fill_sel_r ^ swap_s;
        end
    end

    // Slot table storage; validity is carried by the occupancy bitmaps
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            slot_r[fill_sel_r][wr_addr_s] <= wr_data_s;
        end
    end

    // Occupancy bitmaps
    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_r[0] <= '0;
            occ_r[1] <= '0;
        end else begin
            if (swap_s) begin
                occ_r[issue_sel_s] <= '0;
            end
            if (wr_en_s) begin
                occ_r[fill_sel_r][wr_addr_s] <= 1'b1;
            end
        end
    end

    // Issue side: walk the issue bank in slot order
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_r         <= '0;
            out_valid_r   <= 1'b0;
            out_rule_r    <= '0;
            round_done_r  <= 1'b0;
            round_count_r <= 16'd0;
        end else begin
            round_done_r <= 1'b0;
            if (swap_s) begin
                out_valid_r <= 1'b1;
                ptr_r       <= '0;
                out_rule_r  <= slot_r[fill_sel_r][0];
            end else if (out_valid_r && out_ready) begin
                if (ptr_r == LAST) begin
                    out_valid_r   <= 1'b0;
                    round_done_r  <= 1'b1;
                    round_count_r <= round_count_r + 16'd1;
                end else begin
                    ptr_r      <= ptr_r + PW'(1);
                    out_rule_r <= slot_r[issue_sel_s][ptr_r + PW'(1)];
                end
            end
        end
    end

endmodule

// File: tb/tb_rule_order_seq.sv
// Bench for rule_order_seq: directed rounds plus random rounds checked against a
// slot-placement model built from the priority list of each round.
module tb_rule_order_seq;

    localparam int RULES  = 61;
    localparam int PW     = 6;
    localparam int BUDGET = 3000;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [PW-1:0] in_prio;
    logic          in_ready;
    logic          out_valid;
    logic [PW-1:0] out_rule;
    logic          out_ready;
    logic          round_done;
    logic [15:0]   round_count;

    always #5 clk = ~clk;

    rule_order_seq #(.RULES(RULES), .PW(PW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_prio(in_prio),
        .in_ready(in_ready), .out_valid(out_valid), .out_rule(out_rule),
        .out_ready(out_ready), .round_done(round_done), .round_count(round_count)
    );

    int errors = 0;
    int checks = 0;
    logic [PW-1:0] exp_q[$];
    int hs_idx = 0;
    int rc_exp = 0;
    bit last_hs = 1'b0;
    bit rand_ready = 1'b0;
    int prio_arr[RULES];
    int skip[RULES];
    int stalls[RULES];
    int got[RULES];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock: track handshakes against the expected issue order.
    task automatic tick();
        bit live;
        bit hs;
        bit prev_valid;
        logic [PW-1:0] r;
        live       = (rst === 1'b1);
        hs         = live && (out_valid === 1'b1) && (out_ready === 1'b1);
        prev_valid = (out_valid === 1'b1);
        r          = out_rule;
        @(posedge clk);
        #1;
        last_hs = 1'b0;
        if (live) begin
            if (hs) begin
                check("order_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("order", r, exp_q.pop_front());
                got[hs_idx] = int'(r);
                hs_idx++;
                if (hs_idx == RULES) begin
                    hs_idx  = 0;
                    rc_exp  = (rc_exp + 1) % 65536;
                    last_hs = 1'b1;
                end
            end else if (prev_valid) begin
                check("hold_valid", out_valid, 1);
                check("hold_rule", out_rule, r);
            end
            check("round_done", round_done, last_hs);
            check("round_count", round_count, rc_exp);
        end
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Place prio_arr into a model slot table, then drive the round in.
    task automatic feed();
        bit occ[RULES];
        logic [PW-1:0] slotv[RULES];
        int s;
        int n;
        int stall;
        for (int i = 0; i < RULES; i++) occ[i] = 1'b0;
        for (int k = 0; k < RULES; k++) begin
            s = (prio_arr[k] < RULES) ? prio_arr[k] : 0;
            n = 0;
            while (occ[s]) begin
                s = (s + 1) % RULES;
                n++;
            end
            occ[s]   = 1'b1;
            slotv[s] = PW'(k);
            skip[k]  = n;
        end
        for (int k = 0; k < RULES; k++) begin
            in_valid = 1'b1;
            in_prio  = PW'(prio_arr[k]);
            stall    = 0;
            while (in_ready !== 1'b1 && stall < BUDGET) begin
                tick();
                stall++;
            end
            check("feed_timeout", stall < BUDGET, 1);
            if (k > 0) check("probe_stall", stall, skip[k-1]);
            stalls[k] = stall;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < RULES; i++) exp_q.push_back(slotv[i]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < BUDGET) begin
            tick();
            n++;
        end
        check("drain_timeout", n < BUDGET, 1);
    endtask

    task automatic do_reset(input int cycles);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_prio  = '0;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_round_done", round_done, 0);
        check("rst_round_count", round_count, 0);
        check("rst_out_rule", out_rule, 0);
        rst = 1'b1;
        exp_q.delete();
        hs_idx = 0;
        rc_exp = 0;
        check("rst_in_ready", in_ready, 1);
    endtask

    task automatic random_prios();
        for (int k = 0; k < RULES; k++) prio_arr[k] = int'($urandom_range(0, 63));
    endtask

    initial begin
        int n;
        out_ready = 1'b0;
        do_reset(2);

        // Distinct priorities: reversed order, no stalls
        out_ready = 1'b1;
        for (int k = 0; k < RULES; k++) prio_arr[k] = 60 - k;
        feed();
        drain();
        tick();
        check("dist_first", got[0], 60);
        check("dist_last", got[60], 0);
        check("dist_rounds", round_count, 1);

        // All priorities zero: linear probe grows by one each rule
        for (int k = 0; k < RULES; k++) prio_arr[k] = 0;
        feed();
        check("zero_stall_60", stalls[60], 59);
        drain();
        check("zero_first", got[0], 0);
        check("zero_mid", got[30], 30);
        check("zero_last", got[60], 60);

        // Wrap-around collision and out-of-range priority
        random_prios();
        prio_arr[0] = 60;
        prio_arr[1] = 60;
        prio_arr[2] = 63;
        for (int k = 3; k < RULES; k++) if (prio_arr[k] < 2 || prio_arr[k] == 60) prio_arr[k] = 30;
        feed();
        check("wrap_probe", stalls[2], 1);
        check("oor_probe", stalls[3], 1);
        drain();
        check("wrap_slot0", got[0], 1);
        check("oor_slot1", got[1], 2);
        check("wrap_slot60", got[60], 0);

        // Random rounds with random output backpressure, fill overlapping issue
        rand_ready = 1'b1;
        repeat (3) begin
            random_prios();
            feed();
        end
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        tick();

        // Backpressure: second round fills behind a stalled first round
        random_prios();
        feed();
        n = 0;
        while (out_valid !== 1'b1 && n < BUDGET) begin
            tick();
            n++;
        end
        check("bp_swap_timeout", n < BUDGET, 1);
        out_ready = 1'b0;
        random_prios();
        feed();
        repeat (5) begin
            tick();
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        last_hs = 1'b0;
        n = 0;
        while (!last_hs && n < BUDGET) begin
            tick();
            n++;
        end
        check("bp_drain_timeout", n < BUDGET, 1);
        check("bp_bubble", out_valid, 0);
        check("bp_bubble_full", in_ready, 0);
        tick();
        check("bp_next_valid", out_valid, 1);
        check("bp_next_first", out_rule, exp_q.size() > 0 ? exp_q[0] : PW'(0));
        drain();

        // Reset in the middle of issue
        random_prios();
        feed();
        n = 0;
        while (hs_idx != 30 && n < BUDGET) begin
            tick();
            n++;
        end
        check("mid_timeout", n < BUDGET, 1);
        do_reset(1);
        random_prios();
        feed();
        drain();
        tick();
        check("post_rst_rounds", round_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
